// File: rtl/shadow_dump_collector.sv
// shadow_dump_collector
//
// Purpose: sits downstream of a shadow_capture instance and unloads its scan
// chains one at a time, in ascending chain order. Each chain's serial bits are
// packed LSB-first into bytes. The bytes are queued as records, tagged with
// the chain number, in a small first-word-fall-through FIFO with a
// valid/ready interface toward the debug readout.
//
// Ports:
//   sh_clk       shadow/data clock
//   sh_rst       asynchronous active-high reset
//   start        one-cycle pulse that begins a dump sequence (IDLE only)
//   chain_mask   chains to dump, captured when start is accepted
//   dump_en      one-hot (or zero) dump enable toward shadow_capture
//   ch_out       serial chain data from shadow_capture
//   ch_out_vld   per-chain bit valid
//   ch_out_done  per-chain end-of-chain marker
//   out_valid    head record available
//   out_ready    consumer accepts the head record
//   out_data     packed bits, first received bit in bit 0
//   out_chain    chain number of the head record
//   out_nbits    number of valid bits in out_data (8, or 0-7 for terminal)
//   out_last     head record is the terminal record of its chain
//   busy         a dump sequence is in progress
//   seq_done     one-cycle pulse when the sequence completes
module shadow_dump_collector #(
    parameter int NUM_CHAINS = 8,
    parameter int CH_IDX_W   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  sh_clk,
    input  logic                  sh_rst,
    input  logic                  start,
    input  logic [NUM_CHAINS-1:0] chain_mask,
    output logic [NUM_CHAINS-1:0] dump_en,
    input  logic [NUM_CHAINS-1:0] ch_out,
    input  logic [NUM_CHAINS-1:0] ch_out_vld,
    input  logic [NUM_CHAINS-1:0] ch_out_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic [CH_IDX_W-1:0]   out_chain,
    output logic [3:0]            out_nbits,
    output logic                  out_last,
    output logic                  busy,
    output logic                  seq_done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CH_IDX_W-1:0]   LAST_IDX  = CH_IDX_W'(NUM_CHAINS - 1);
    localparam logic [CNT_W-1:0]      STALL_LVL = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL_LVL  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [NUM_CHAINS-1:0] EN_ONE    = NUM_CHAINS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_DUMP,
        S_FLUSH,
        S_FIN
    } state_t;

    typedef struct packed {
        logic [7:0]          data;
        logic [CH_IDX_W-1:0] chain;
        logic [3:0]          nbits;
        logic                last;
    } rec_t;

    state_t                state, state_nxt;
    logic [CH_IDX_W-1:0]   idx, idx_nxt;
    logic [NUM_CHAINS-1:0] mask, mask_nxt;
    logic [7:0]            sreg, sreg_nxt;
    logic [3:0]            cnt, cnt_nxt;

    logic                  push;
    rec_t                  push_rec;
    logic                  pop;

    rec_t                  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr, rptr;
    logic [CNT_W-1:0]      fcount, fcount_nxt;

    logic                  bit_vld, bit_val, bit_done;
    logic [7:0]            shifted;

    // Only the currently selected chain is listened to.
    assign bit_vld  = ch_out_vld[idx];
    assign bit_val  = ch_out[idx];
    assign bit_done = ch_out_done[idx];
    assign shifted  = sreg | ({7'd0, bit_val} << cnt);

    assign pop        = out_valid && out_ready;
    assign fcount_nxt = fcount + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge sh_clk or posedge sh_rst) begin
        if (sh_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mask_nxt  = mask;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        push      = 1'b0;
        push_rec  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    mask_nxt  = chain_mask;
                    idx_nxt   = '0;
                    state_nxt = S_SEL;
                end
            end
            S_SEL: begin
                if (mask[idx]) begin
                    sreg_nxt  = '0;
                    cnt_nxt   = '0;
                    state_nxt = S_DUMP;
                end else if (idx == LAST_IDX) begin
                    state_nxt = S_FIN;
                end else begin
                    idx_nxt = idx + CH_IDX_W'(1);
                end
            end
            S_DUMP: begin
                // A bit arriving with done is taken first, so it lands in the
                // terminal record (or completes a final full byte).
                if (bit_vld) begin
                    if (cnt == 4'd7) begin
                        push     = 1'b1;
                        push_rec = '{data: shifted, chain: idx, nbits: 4'd8, last: 1'b0};
                        sreg_nxt = '0;
                        cnt_nxt  = '0;
                    end else begin
                        sreg_nxt = shifted;
                        cnt_nxt  = cnt + 4'd1;
                    end
                end
                if (bit_done) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Terminal record is always written, even with zero bits, so
                // the reader sees an explicit end for every dumped chain.
                if (fcount != FULL_LVL) begin
                    push     = 1'b1;
                    push_rec = '{data: sreg, chain: idx, nbits: cnt, last: 1'b1};
                    if (idx == LAST_IDX) begin
                        state_nxt = S_FIN;
                    end else begin
                        idx_nxt   = idx + CH_IDX_W'(1);
                        state_nxt = S_SEL;
                    end
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sh_clk or posedge sh_rst) begin
        if (sh_rst) begin
            idx      <= '0;
            mask     <= '0;
            sreg     <= '0;
            cnt      <= '0;
            dump_en  <= '0;
            busy     <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            idx      <= idx_nxt;
            mask     <= mask_nxt;
            sreg     <= sreg_nxt;
            cnt      <= cnt_nxt;
            // Enable is withheld once the FIFO has one slot left: the single
            // bit shadow_capture may still deliver after the drop can complete
            // at most one byte, which that slot absorbs.
            if (state_nxt == S_DUMP && fcount_nxt < STALL_LVL) begin
                dump_en <= EN_ONE << idx_nxt;
            end else begin
                dump_en <= '0;
            end
            busy     <= (state_nxt != S_IDLE);
            seq_done <= (state_nxt == S_FIN);
        end
    end

    // Record FIFO, first-word fall-through: outputs always show the head.
    always_ff @(posedge sh_clk or posedge sh_rst) begin
        if (sh_rst) begin
            wptr      <= '0;
            rptr      <= '0;
            fcount    <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= push_rec;
                wptr      <= (wptr == PTR_LAST) ? '0 : wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + PTR_W'(1);
            end
            fcount    <= fcount_nxt;
            out_valid <= (fcount_nxt != '0);
        end
    end

    assign out_data  = mem[rptr].data;
    assign out_chain = mem[rptr].chain;
    assign out_nbits = mem[rptr].nbits;
    assign out_last  = mem[rptr].last;

endmodule
